// File: rtl/hazard_sequencer.sv
// hazard_sequencer: hazard and redirect controller for the 5-stage MIPS core.
// Sits between IF, ID and EX. It detects load-use and branch-operand hazards,
// arbitrates EX jump redirects against ID branch redirects, and holds a
// redirect pending while instruction memory is not ready.
//
// Ports:
//   i_clk, i_rst                   clock / async active-high reset
//   i_id_*                         ID-stage source regs, use flags, branch info
//   i_ex_*                         EX-stage load / writeback / dest / jump redirect
//   i_mem_mem_read, i_mem_rd       MEM-stage load and destination
//   i_imem_ready                   instruction memory accepts a fetch
//   o_pc_write, o_ifid_write       PC / IF-ID load enables
//   o_ifid_flush, o_idex_flush     bubble insertion
//   o_redirect, o_target           PC redirect and its target
//   o_state                        FSM state (RUN=0, STALL=1, PENDING=2)
//   o_stall_cycles                 saturating count of hazard stall cycles
module hazard_sequencer #(
  parameter int PC_WIDTH   = 32,
  parameter int REG_AWIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_AWIDTH-1:0] i_id_rs,
  input  logic [REG_AWIDTH-1:0] i_id_rt,
  input  logic                  i_id_use_rs,
  input  logic                  i_id_use_rt,
  input  logic                  i_id_branch,
  input  logic                  i_id_taken,
  input  logic [PC_WIDTH-1:0]   i_id_target,
  input  logic                  i_ex_mem_read,
  input  logic                  i_ex_reg_write,
  input  logic [REG_AWIDTH-1:0] i_ex_rd,
  input  logic                  i_mem_mem_read,
  input  logic [REG_AWIDTH-1:0] i_mem_rd,
  input  logic                  i_ex_change_pc,
  input  logic [PC_WIDTH-1:0]   i_ex_target,
  input  logic                  i_imem_ready,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_idex_flush,
  output logic                  o_redirect,
  output logic [PC_WIDTH-1:0]   o_target,
  output logic [1:0]            o_state,
  output logic [CNT_WIDTH-1:0]  o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   target_q, target_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic m_ex, m_mem, lu, bh;

  // Register 0 is hardwired to zero, so it never creates a dependency.
  assign m_ex  = (i_ex_rd != '0) &&
                 ((i_id_use_rs && (i_id_rs == i_ex_rd)) ||
                  (i_id_use_rt && (i_id_rt == i_ex_rd)));
  assign m_mem = (i_mem_rd != '0) &&
                 ((i_id_use_rs && (i_id_rs == i_mem_rd)) ||
                  (i_id_use_rt && (i_id_rt == i_mem_rd)));

  assign lu = i_ex_mem_read & m_ex;
  // A branch compares in ID, so it must wait for any EX producer and for a
  // load still in MEM; a load ahead of a branch thus stalls twice.
  assign bh = i_id_branch & ((i_ex_reg_write & m_ex) | (i_mem_mem_read & m_mem));

  always_comb begin
    o_pc_write   = 1'b1;
    o_ifid_write = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    o_redirect   = 1'b0;
    o_target     = '0;
    state_d      = RUN;
    target_d     = target_q;
    cnt_d        = cnt_q;

    if (state_q == PENDING) begin
      // Keep steering fetch at the held target until imem takes it. A newer
      // EX jump supersedes the held target; ID hazards are on the wrong path.
      o_redirect   = 1'b1;
      o_ifid_flush = 1'b1;
      o_pc_write   = i_imem_ready;
      if (i_ex_change_pc) begin
        o_target     = i_ex_target;
        o_idex_flush = 1'b1;
        target_d     = i_ex_target;
      end else begin
        o_target     = target_q;
      end
      state_d = i_imem_ready ? RUN : PENDING;
    end else if (i_ex_change_pc) begin
      o_redirect   = 1'b1;
      o_target     = i_ex_target;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      if (!i_imem_ready) begin
        target_d = i_ex_target;
        state_d  = PENDING;
      end
    end else if (lu | bh) begin
      o_pc_write   = 1'b0;
      o_ifid_write = 1'b0;
      o_idex_flush = 1'b1;
      state_d      = STALL;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (i_id_branch && i_id_taken) begin
      o_redirect   = 1'b1;
      o_target     = i_id_target;
      o_ifid_flush = 1'b1;
      if (!i_imem_ready) begin
        target_d = i_id_target;
        state_d  = PENDING;
      end
    end else if (!i_imem_ready) begin
      // Fetch bubble: hold PC, feed a bubble into ID.
      o_pc_write   = 1'b0;
      o_ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= RUN;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_state        = state_q;
  assign o_stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed-vector bench for hazard_sequencer. The driver applies one vector
// per cycle and queues the hand-computed response; a monitor pops and
// compares at each falling edge.
module tb_hazard_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [4:0]  i_id_rs, i_id_rt, i_ex_rd, i_mem_rd;
  logic        i_id_use_rs, i_id_use_rt, i_id_branch, i_id_taken;
  logic [31:0] i_id_target, i_ex_target;
  logic        i_ex_mem_read, i_ex_reg_write, i_mem_mem_read;
  logic        i_ex_change_pc, i_imem_ready;
  logic        o_pc_write, o_ifid_write, o_ifid_flush, o_idex_flush, o_redirect;
  logic [31:0] o_target;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cycles;

  hazard_sequencer #(.PC_WIDTH(32), .REG_AWIDTH(5), .CNT_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_id_use_rs(i_id_use_rs), .i_id_use_rt(i_id_use_rt),
    .i_id_branch(i_id_branch), .i_id_taken(i_id_taken), .i_id_target(i_id_target),
    .i_ex_mem_read(i_ex_mem_read), .i_ex_reg_write(i_ex_reg_write), .i_ex_rd(i_ex_rd),
    .i_mem_mem_read(i_mem_mem_read), .i_mem_rd(i_mem_rd),
    .i_ex_change_pc(i_ex_change_pc), .i_ex_target(i_ex_target),
    .i_imem_ready(i_imem_ready),
    .o_pc_write(o_pc_write), .o_ifid_write(o_ifid_write),
    .o_ifid_flush(o_ifid_flush), .o_idex_flush(o_idex_flush),
    .o_redirect(o_redirect), .o_target(o_target),
    .o_state(o_state), .o_stall_cycles(o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic [54:0] v;  // {pcw, ifw, iff, ief, red, tgt[31:0], st[1:0], cnt[15:0]}
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [54:0] act;
      e   = q.pop_front();
      act = {o_pc_write, o_ifid_write, o_ifid_flush, o_idex_flush, o_redirect,
             o_target, o_state, o_stall_cycles};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got pcw/ifw/iff/ief/red=%b tgt=%h st=%0d cnt=%h, need %b tgt=%h st=%0d cnt=%h",
                 e.name, act[54:50], act[49:18], act[17:16], act[15:0],
                 e.v[54:50], e.v[49:18], e.v[17:16], e.v[15:0]);
      end
    end
  end

  task automatic idle();
    i_id_rs = 0; i_id_rt = 0; i_id_use_rs = 0; i_id_use_rt = 0;
    i_id_branch = 0; i_id_taken = 0; i_id_target = 0;
    i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_rd = 0;
    i_mem_mem_read = 0; i_mem_rd = 0;
    i_ex_change_pc = 0; i_ex_target = 0; i_imem_ready = 1;
  endtask

  // Queue the expected response for the vector currently driven, then
  // advance one cycle.
  task automatic step(input string n, input logic [4:0] flags, input logic [31:0] tgt,
                      input logic [1:0] st, input logic [15:0] cnt);
    exp_t e;
    e.name = n;
    e.v    = {flags, tgt, st, cnt};
    q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors unchecked", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1;
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    //                     pcw ifw iff ief red
    step("reset",          5'b11000, 32'h0, 2'd0, 16'd0);
    i_rst = 1'b0;
    step("idle",           5'b11000, 32'h0, 2'd0, 16'd0);

    // Load-use
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 8; i_id_rs = 8; i_id_use_rs = 1;
    step("lu_stall",       5'b00010, 32'h0, 2'd0, 16'd0);
    idle(); i_mem_mem_read = 1; i_mem_rd = 8; i_id_rs = 8; i_id_use_rs = 1;
    step("lu_after",       5'b11000, 32'h0, 2'd1, 16'd1);
    idle();
    step("lu_run",         5'b11000, 32'h0, 2'd0, 16'd1);

    // rd=0 and unused-source immunity
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 0; i_id_rs = 0; i_id_use_rs = 1;
    step("rd0_immune",     5'b11000, 32'h0, 2'd0, 16'd1);
    idle(); i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 7; i_id_rs = 7;
    step("unused_rs",      5'b11000, 32'h0, 2'd0, 16'd1);

    // Branch behind a load: EX match then MEM match, then resolve taken
    idle(); i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 9;
    i_id_branch = 1; i_id_rs = 9; i_id_use_rs = 1; i_id_rt = 3; i_id_use_rt = 1;
    step("bh_ex",          5'b00010, 32'h0, 2'd0, 16'd1);
    i_ex_mem_read = 0; i_ex_reg_write = 0; i_ex_rd = 0; i_mem_mem_read = 1; i_mem_rd = 9;
    step("bh_mem",         5'b00010, 32'h0, 2'd1, 16'd2);
    i_mem_mem_read = 0; i_mem_rd = 0; i_id_taken = 1; i_id_target = 32'h40;
    step("br_taken",       5'b11101, 32'h40, 2'd1, 16'd3);
    idle();
    step("br_idle",        5'b11000, 32'h0, 2'd0, 16'd3);

    // ALU producer feeding branch via rt; MEM non-load producer does not stall
    i_ex_reg_write = 1; i_ex_rd = 5; i_id_branch = 1; i_id_rt = 5; i_id_use_rt = 1;
    step("bh_alu",         5'b00010, 32'h0, 2'd0, 16'd3);
    idle(); i_mem_rd = 5; i_id_branch = 1; i_id_rt = 5; i_id_use_rt = 1;
    step("mem_alu_ok",     5'b11000, 32'h0, 2'd1, 16'd4);

    // EX jump beats ID taken branch and a load-use hazard
    idle(); i_ex_change_pc = 1; i_ex_target = 32'h100;
    i_id_branch = 1; i_id_taken = 1; i_id_target = 32'h40;
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 6; i_id_rs = 6; i_id_use_rs = 1;
    step("ex_wins",        5'b11111, 32'h100, 2'd0, 16'd4);
    idle();
    step("ex_after",       5'b11000, 32'h0, 2'd0, 16'd4);

    // Fetch bubble
    i_imem_ready = 0;
    step("fetch_bubble",   5'b01100, 32'h0, 2'd0, 16'd4);

    // Pending redirect from ID, imem busy for 3 cycles, hazard ignored
    idle(); i_imem_ready = 0; i_id_branch = 1; i_id_taken = 1; i_id_target = 32'h80;
    step("pend_enter",     5'b11101, 32'h80, 2'd0, 16'd4);
    idle(); i_imem_ready = 0;
    i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 8; i_id_rs = 8; i_id_use_rs = 1;
    step("pend_hold_lu",   5'b01101, 32'h80, 2'd2, 16'd4);
    idle(); i_imem_ready = 0;
    step("pend_hold",      5'b01101, 32'h80, 2'd2, 16'd4);
    idle();
    step("pend_exit",      5'b11101, 32'h80, 2'd2, 16'd4);
    step("pend_done",      5'b11000, 32'h0, 2'd0, 16'd4);

    // Second pending run: EX redirect overwrites latched target
    i_imem_ready = 0; i_id_branch = 1; i_id_taken = 1; i_id_target = 32'h80;
    step("pend2_enter",    5'b11101, 32'h80, 2'd0, 16'd4);
    idle(); i_imem_ready = 0; i_ex_change_pc = 1; i_ex_target = 32'hC0;
    step("pend2_exjump",   5'b01111, 32'hC0, 2'd2, 16'd4);
    idle(); i_imem_ready = 0;
    step("pend2_hold",     5'b01101, 32'hC0, 2'd2, 16'd4);
    idle();
    step("pend2_exit",     5'b11101, 32'hC0, 2'd2, 16'd4);
    step("pend2_done",     5'b11000, 32'h0, 2'd0, 16'd4);

    // Reset in the middle of PENDING
    i_imem_ready = 0; i_id_branch = 1; i_id_taken = 1; i_id_target = 32'h80;
    step("pend3_enter",    5'b11101, 32'h80, 2'd0, 16'd4);
    idle(); i_imem_ready = 0;
    step("pend3_hold",     5'b01101, 32'h80, 2'd2, 16'd4);
    idle(); i_rst = 1'b1;
    step("reset_mid",      5'b11000, 32'h0, 2'd0, 16'd0);
    i_rst = 1'b0; i_imem_ready = 0;
    step("target_dropped", 5'b01100, 32'h0, 2'd0, 16'd0);

    // Saturation: hold a load-use hazard past 2^16 cycles
    idle(); i_ex_mem_read = 1; i_ex_reg_write = 1; i_ex_rd = 8; i_id_rs = 8; i_id_use_rs = 1;
    for (int i = 0; i < 65537; i++) begin
      logic [15:0] c;
      c = (i > 65535) ? 16'hFFFF : i[15:0];
      step("sat_stall", 5'b00010, 32'h0, (i == 0) ? 2'd0 : 2'd1, c);
    end
    idle();
    step("sat_hold",       5'b11000, 32'h0, 2'd1, 16'hFFFF);
    step("sat_run",        5'b11000, 32'h0, 2'd0, 16'hFFFF);

    @(posedge i_clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d vectors left unchecked, need 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
